systolic_out_quant: RTL and testbench
=====================================

// Module: systolic_out_quant
// PURPOSE
//  Downstream stage of the systolic MAC array. Steps the array's matrix_index
//  through one tile's ARRAY_SIZE output vectors and captures each vector of
//  ORI_WIDTH signed partial sums. Applies bias, round-shift, optional ReLU and
//  saturation to int8, then packs the lanes into SRAM words for the output buffer.
//  Handshaked at both ends; a stall propagates back through all stages.
// PARAMETERS
//  ARRAY_SIZE       8    lanes per output vector; vectors per tile
//  SRAM_DATA_WIDTH  32   bits per output SRAM word
//  DATA_WIDTH       8    quantized output width (signed)
//  QUEUE_SIZE       4    lanes per SRAM word (SRAM_DATA_WIDTH/DATA_WIDTH)
//  QUEUE_COUNT      ceil(ARRAY_SIZE/QUEUE_SIZE)  SRAM words per vector
//  MATRIX_BITS      6    matrix_index width
//  ORI_WIDTH        21   partial-sum width (2*DATA_WIDTH+5)
//  ADDR_BITS        10   output SRAM address width
// PORTS
//  clk            in   1                         clock
//  srstn          in   1                         synchronous active-low reset
//  start          in   1                         1-cycle pulse: begin tile
//  cfg_base_addr  in   ADDR_BITS                 address of vector 0; sampled at start
//  cfg_shift      in   5                         right shift 0..31; sampled at start
//  cfg_bias       in   ORI_WIDTH (signed)        bias added to every lane; sampled at start
//  vec_valid      in   1                         mul_outcome holds the vector at matrix_index
//  vec_ready      out  1                         stage can accept a vector this cycle
//  matrix_index   out  MATRIX_BITS               vector select driven to the array
//  mul_outcome    in   ARRAY_SIZE*ORI_WIDTH      packed partial sums; lane i at [i*ORI_WIDTH +: ORI_WIDTH]
//  out_valid      out  1                         out_wdata/out_addr valid
//  out_ready      in   1                         output SRAM writer accepts
//  out_addr       out  ADDR_BITS                 cfg_base_addr + vector number
//  out_wdata      out  QUEUE_COUNT*SRAM_DATA_WIDTH  packed quantized lanes
//  busy           out  1                         FSM not IDLE
//  done           out  1                         1-cycle pulse: last word accepted
// BEHAVIOUR
//  Reset: all state clears; every output 0, FSM=IDLE, pipeline valids 0.
//   Applies mid-tile too; no partial write is issued after reset.
//  Handshakes
//   - Accept when vec_valid & vec_ready.
//   - Output transfer when out_valid & out_ready.
//   - out_valid/out_addr/out_wdata hold stable until accepted.
//  FSM
//   IDLE  -> RUN on start. Latch cfg_*, matrix_index=0, vector count=0.
//   RUN   each accept: matrix_index++. Accept of vector ARRAY_SIZE-1 -> FLUSH,
//         matrix_index returns to 0.
//   FLUSH vec_ready=0. When pipeline is empty and the last word is accepted:
//         done=1 for 1 cycle, -> IDLE.
//   start outside IDLE is ignored. vec_valid outside RUN is ignored.
//  Pipeline (global enable en = ~out_valid | out_ready)
//   S1  capture: s = lane + cfg_bias, ORI_WIDTH+1 bit signed.
//   S2  r = (s + (shift?1<<(shift-1):0)) >>> shift, then saturate to
//       [-2^(DW-1), 2^(DW-1)-1]. Round half up; arithmetic shift.
//   S3  pack to output register.
//       - Lane i -> word i/QUEUE_SIZE, bits
//         [(QUEUE_SIZE-1-i%QUEUE_SIZE)*DW +: DW] (MSB-first).
//       - Unused lanes are 0.
//   vec_ready = (state==RUN) & en.
//   Latency: accept at cycle t -> out_valid at t+2 if no stall.
//   Throughput: 1 vector/cycle at full rate.
//   Simultaneous accept and output transfer in one cycle is legal and lossless.
//   Vector count does not wrap past ARRAY_SIZE-1 within a tile.
// CONFIGURATION
//  QUANT_RELU_EN defined:
//   - After rounding, negative r is clamped to 0 before saturation.
//   - Range becomes [0, 2^(DW-1)-1].
//  Not defined: full signed saturation only. No ReLU logic is generated.
// STRUCTURE
//  Shared package:
//   - lane-width localparams (ORI_WIDTH, SUM_WIDTH=ORI_WIDTH+1).
//   - FSM state encoding (IDLE/RUN/FLUSH).
//   - INT8 min/max constants.
//  Sub-module out_quant_lane (one per lane, generate loop):
//   - bias add, round-shift, ReLU, saturate.
//   - Combinational core with stage registers in the parent.
// TESTING
//  1. Reset, then start with shift=0, bias=0. All lanes = 5.
//     -> 8 writes, every byte 0x05, addr base..base+7, done once.
//  2. Lane 0 = 300, shift=1.
//     -> 150 saturates to 0x7F. Lane 0 = -300 -> 0x80.
//  3. Lane = 3, shift=1 -> 2 (round half up). Lane = -3, shift=1 -> -1 (0xFF).
//     Bias=-10, lane=4, shift=0 -> 0xFA; with QUANT_RELU_EN -> 0x00.
//  4. out_ready low 5 cycles mid-tile.
//     -> out_wdata/out_addr stable, vec_ready=0, matrix_index frozen.
//     -> no vector lost or duplicated; order preserved.
//  5. srstn low in RUN after 3 vectors.
//     -> outputs 0 next cycle. New start produces a clean 8-vector tile.
//  6. start pulsed during RUN -> ignored.
//     Back-to-back tiles: second start in cycle after done -> correct addresses.

Source files
------------

// File: rtl/systolic_out_quant_pkg.sv
// Shared lane widths, saturation limits and FSM encoding for the systolic output quantizer.
// Optional ReLU clamp is selected with the QUANT_RELU_EN macro (see out_quant_lane).
package systolic_out_quant_pkg;

    localparam int LANE_DATA_WIDTH = 8;
    localparam int LANE_ORI_WIDTH  = 2 * LANE_DATA_WIDTH + 5;
    localparam int LANE_SUM_WIDTH  = LANE_ORI_WIDTH + 1;
    // Wide enough for a sign-extended sum plus the 2^30 rounding term at shift 31.
    localparam int LANE_RND_WIDTH  = 33;

    localparam logic signed [LANE_DATA_WIDTH-1:0] INT8_MIN = -8'sd128;
    localparam logic signed [LANE_DATA_WIDTH-1:0] INT8_MAX = 8'sd127;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/out_quant_lane.sv
// Per-lane combinational core: bias add (feeds S1) and round-shift/ReLU/saturate (feeds S3).
// ReLU clamp is built only when QUANT_RELU_EN is defined.
module out_quant_lane
    import systolic_out_quant_pkg::*;
(
    input  logic signed [LANE_ORI_WIDTH-1:0]  lane,
    input  logic signed [LANE_ORI_WIDTH-1:0]  bias,
    output logic signed [LANE_SUM_WIDTH-1:0]  sum,
    input  logic signed [LANE_SUM_WIDTH-1:0]  stage_sum,
    input  logic        [4:0]                 shift,
    output logic        [LANE_DATA_WIDTH-1:0] q
);

    localparam logic signed [LANE_RND_WIDTH-1:0] SAT_HI = LANE_RND_WIDTH'(INT8_MAX);
    localparam logic signed [LANE_RND_WIDTH-1:0] SAT_LO = LANE_RND_WIDTH'(INT8_MIN);

    logic signed [LANE_RND_WIDTH-1:0] ext;
    logic signed [LANE_RND_WIDTH-1:0] rnd;
    logic signed [LANE_RND_WIDTH-1:0] r;
    logic signed [LANE_RND_WIDTH-1:0] c;

    assign sum = LANE_SUM_WIDTH'(lane) + LANE_SUM_WIDTH'(bias);

    // NOTE: every variable gets a value before any branch, so no latch can be inferred.
    always_comb begin
        ext = LANE_RND_WIDTH'(stage_sum);
        rnd = (shift == 5'd0) ? '0 : (LANE_RND_WIDTH'(1) << (shift - 5'd1));
        r   = (ext + rnd) >>> shift;
        c   = r;
`ifdef QUANT_RELU_EN
        if (r[LANE_RND_WIDTH-1]) begin
            c = '0;
        end
`endif
        if (c > SAT_HI) begin
            q = INT8_MAX;
        end else if (c < SAT_LO) begin
            q = INT8_MIN;
        end else begin
            q = c[LANE_DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/systolic_out_quant.sv
// Output stage of the systolic MAC array: walks matrix_index over one tile, quantizes each
// vector to int8 and writes packed SRAM words. QUANT_RELU_EN enables the ReLU clamp.
module systolic_out_quant
    import systolic_out_quant_pkg::*;
#(
    parameter int ARRAY_SIZE      = 8,
    parameter int SRAM_DATA_WIDTH = 32,
    parameter int DATA_WIDTH      = LANE_DATA_WIDTH,
    parameter int QUEUE_SIZE      = SRAM_DATA_WIDTH / DATA_WIDTH,
    parameter int QUEUE_COUNT     = (ARRAY_SIZE + QUEUE_SIZE - 1) / QUEUE_SIZE,
    parameter int MATRIX_BITS     = 6,
    parameter int ORI_WIDTH       = LANE_ORI_WIDTH,
    parameter int ADDR_BITS       = 10
) (
    input  logic                                   clk,
    input  logic                                   srstn,
    input  logic                                   start,
    input  logic [ADDR_BITS-1:0]                   cfg_base_addr,
    input  logic [4:0]                             cfg_shift,
    input  logic signed [ORI_WIDTH-1:0]            cfg_bias,
    input  logic                                   vec_valid,
    output logic                                   vec_ready,
    output logic [MATRIX_BITS-1:0]                 matrix_index,
    input  logic [ARRAY_SIZE*ORI_WIDTH-1:0]        mul_outcome,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [ADDR_BITS-1:0]                   out_addr,
    output logic [QUEUE_COUNT*SRAM_DATA_WIDTH-1:0] out_wdata,
    output logic                                   busy,
    output logic                                   done
);

    state_e state;
    state_e state_next;

    logic [ADDR_BITS-1:0]        base_q;
    logic [4:0]                  shift_q;
    logic signed [ORI_WIDTH-1:0] bias_q;

    logic en;
    logic accept;
    logic last_vec;

    logic                   s1_valid;
    logic [MATRIX_BITS-1:0] s1_idx;

    logic signed [LANE_SUM_WIDTH-1:0]  lane_sum [ARRAY_SIZE];
    logic signed [LANE_SUM_WIDTH-1:0]  s1_sum   [ARRAY_SIZE];
    logic        [DATA_WIDTH-1:0]      lane_q   [ARRAY_SIZE];
    logic [QUEUE_COUNT*SRAM_DATA_WIDTH-1:0] packed_word;

    // One stall signal freezes every stage, so nothing is dropped or duplicated.
    assign en       = ~out_valid | out_ready;
    assign last_vec = (matrix_index == MATRIX_BITS'(ARRAY_SIZE - 1));
    assign accept   = vec_valid & vec_ready;
    assign busy     = (state != IDLE);

    always_comb begin
        state_next = state;
        vec_ready  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                vec_ready = en;
                if (vec_valid && en && last_vec) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (!s1_valid && out_valid && out_ready) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            base_q       <= '0;
            shift_q      <= '0;
            bias_q       <= '0;
            matrix_index <= '0;
        end else if (state == IDLE && start) begin
            base_q       <= cfg_base_addr;
            shift_q      <= cfg_shift;
            bias_q       <= cfg_bias;
            matrix_index <= '0;
        end else if (accept) begin
            matrix_index <= last_vec ? '0 : matrix_index + MATRIX_BITS'(1);
        end
    end

    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
        out_quant_lane u_lane (
            .lane      (mul_outcome[i*ORI_WIDTH +: ORI_WIDTH]),
            .bias      (bias_q),
            .sum       (lane_sum[i]),
            .stage_sum (s1_sum[i]),
            .shift     (shift_q),
            .q         (lane_q[i])
        );
    end

    // Lane i lands in word i/QUEUE_SIZE with the lowest lane in the top byte.
    always_comb begin
        packed_word = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            packed_word[(i / QUEUE_SIZE) * SRAM_DATA_WIDTH
                        + (QUEUE_SIZE - 1 - (i % QUEUE_SIZE)) * DATA_WIDTH +: DATA_WIDTH] = lane_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            s1_valid  <= 1'b0;
            s1_idx    <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_wdata <= '0;
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                s1_sum[i] <= '0;
            end
        end else if (en) begin
            s1_valid  <= accept;
            s1_idx    <= matrix_index;
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                s1_sum[i] <= lane_sum[i];
            end
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_addr  <= base_q + ADDR_BITS'(s1_idx);
                out_wdata <= packed_word;
            end
        end
    end

endmodule

// File: tb/tb_systolic_out_quant.sv
// Directed bench for systolic_out_quant: quantization corners, stalls, mid-tile reset, restarts.
// Expectations follow the ReLU variant when QUANT_RELU_EN is defined.
module tb_systolic_out_quant;

    localparam int AS = 8;
    localparam int OW = 21;

    logic              clk;
    logic              srstn;
    logic              start;
    logic [9:0]        cfg_base_addr;
    logic [4:0]        cfg_shift;
    logic signed [20:0] cfg_bias;
    logic              vec_valid;
    logic              vec_ready;
    logic [5:0]        matrix_index;
    logic [AS*OW-1:0]  mul_outcome;
    logic              out_valid;
    logic              out_ready;
    logic [9:0]        out_addr;
    logic [63:0]       out_wdata;
    logic              busy;
    logic              done;

    logic signed [20:0] tile_data [AS][AS];
    logic [7:0]         exp_byte  [AS][AS];
    logic [9:0]         got_addr [$];
    logic [63:0]        got_data [$];
    int done_cnt = 0;
    int first_valid;
    int total = 0;
    int bad = 0;

    systolic_out_quant dut (
        .clk           (clk),
        .srstn         (srstn),
        .start         (start),
        .cfg_base_addr (cfg_base_addr),
        .cfg_shift     (cfg_shift),
        .cfg_bias      (cfg_bias),
        .vec_valid     (vec_valid),
        .vec_ready     (vec_ready),
        .matrix_index  (matrix_index),
        .mul_outcome   (mul_outcome),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_addr      (out_addr),
        .out_wdata     (out_wdata),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behaves like the MAC array: presents the vector selected by matrix_index.
    always_comb begin
        mul_outcome = '0;
        for (int l = 0; l < AS; l++) begin
            mul_outcome[l*OW +: OW] = tile_data[matrix_index[2:0]][l];
        end
    end

    always @(negedge clk) begin
        if (srstn) begin
            if (out_valid && out_ready) begin
                got_addr.push_back(out_addr);
                got_data.push_back(out_wdata);
            end
            if (done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] neg(input logic [7:0] b);
`ifdef QUANT_RELU_EN
        return b & 8'h00;
`else
        return b;
`endif
    endfunction

    function automatic logic [63:0] exp_word(input int v);
        return {exp_byte[v][4], exp_byte[v][5], exp_byte[v][6], exp_byte[v][7],
                exp_byte[v][0], exp_byte[v][1], exp_byte[v][2], exp_byte[v][3]};
    endfunction

    task automatic do_stall(input string name);
        logic [63:0] snap_d;
        logic [9:0]  snap_a;
        logic [5:0]  snap_i;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                snap_d = out_wdata;
                snap_a = out_addr;
                snap_i = matrix_index;
            end else begin
                check($sformatf("%s stall%0d wdata", name, k), out_wdata, snap_d);
                check($sformatf("%s stall%0d addr", name, k), 64'(out_addr), 64'(snap_a));
                check($sformatf("%s stall%0d index", name, k), 64'(matrix_index), 64'(snap_i));
            end
            check($sformatf("%s stall%0d out_valid", name, k), 64'(out_valid), 64'd1);
            check($sformatf("%s stall%0d vec_ready", name, k), 64'(vec_ready), 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
    endtask

    task automatic run_tile(input string name, input logic [9:0] base, input logic [4:0] shift,
                            input logic signed [20:0] bias, input int stall_at, input int restart_at);
        int q0, d0, cyc, n;
        q0 = got_data.size();
        d0 = done_cnt;
        first_valid = -1;
        cfg_base_addr = base;
        cfg_shift = shift;
        cfg_bias = bias;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (done_cnt == d0 && cyc < 300) begin
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (cyc == restart_at) begin
                cfg_base_addr = 10'h3FF;
                start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
                cfg_base_addr = base;
                cyc++;
            end else if (cyc == stall_at) begin
                do_stall(name);
                cyc += 5;
            end else begin
                @(posedge clk);
                #1 cyc++;
            end
        end
        check({name, " done seen"}, 64'(done_cnt - d0), 64'd1);
        n = got_data.size() - q0;
        check({name, " word count"}, 64'(n), 64'd8);
        for (int v = 0; v < AS; v++) begin
            if (v < n) begin
                check($sformatf("%s v%0d data", name, v), got_data[q0+v], exp_word(v));
                check($sformatf("%s v%0d addr", name, v), 64'(got_addr[q0+v]), 64'(base + 10'(v)));
            end
        end
    endtask

    initial begin
        logic signed [20:0] pat [8];
        logic [7:0]         pb  [8];
        int d, q0, n;

        srstn = 1'b0;
        start = 1'b0;
        cfg_base_addr = '0;
        cfg_shift = '0;
        cfg_bias = '0;
        vec_valid = 1'b1;
        out_ready = 1'b1;
        for (int v = 0; v < AS; v++)
            for (int l = 0; l < AS; l++) begin
                tile_data[v][l] = '0;
                exp_byte[v][l] = '0;
            end
        repeat (3) @(posedge clk);
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst vec_ready", 64'(vec_ready), 64'd0);
        check("rst index", 64'(matrix_index), 64'd0);
        check("rst wdata", out_wdata, 64'd0);
        check("rst addr", 64'(out_addr), 64'd0);
        check("rst done", 64'(done), 64'd0);
        srstn = 1'b1;
        @(posedge clk);
        #1;

        // All lanes 5, no shift/bias; check latency and a single done pulse.
        for (int v = 0; v < AS; v++)
            for (int l = 0; l < AS; l++) begin
                tile_data[v][l] = 21'sd5;
                exp_byte[v][l] = 8'h05;
            end
        d = done_cnt;
        run_tile("t1", 10'h100, 5'd0, 21'sd0, -1, -1);
        check("t1 latency", 64'(first_valid), 64'd2);
        repeat (4) @(posedge clk);
        #1;
        check("t1 done once", 64'(done_cnt - d), 64'd1);
        check("t1 idle busy", 64'(busy), 64'd0);

        // shift=1: saturation both ways, round half up, arithmetic shift.
        pat = '{21'sd300, -21'sd300, 21'sd3, -21'sd3, 21'sd0, -21'sd1, 21'sd255, -21'sd256};
        pb  = '{8'h7F, neg(8'h80), 8'h02, neg(8'hFF), 8'h00, 8'h00, 8'h7F, neg(8'h80)};
        for (int v = 0; v < AS; v++)
            for (int l = 0; l < AS; l++) begin
                tile_data[v][l] = (l == 4) ? 21'(2 * v) : pat[l];
                exp_byte[v][l] = (l == 4) ? 8'(v) : pb[l];
            end
        run_tile("t2", 10'h010, 5'd1, 21'sd0, -1, -1);

        // Bias -10, shift 0: saturation edges at +127/-128.
        pat = '{21'sd4, 21'sd137, 21'sd138, -21'sd118, -21'sd119, 21'sd10, 21'sd0, -21'sd1000000};
        pb  = '{neg(8'hFA), 8'h7F, 8'h7F, neg(8'h80), neg(8'h80), 8'h00, neg(8'hF6), neg(8'h80)};
        for (int v = 0; v < AS; v++)
            for (int l = 0; l < AS; l++) begin
                tile_data[v][l] = (l == 5) ? 21'(10 + v) : pat[l];
                exp_byte[v][l] = (l == 5) ? 8'(v) : pb[l];
            end
        run_tile("t3a", 10'h020, 5'd0, -21'sd10, -1, -1);

        // Large shift: rounding constant 2^19, half-up at both signs.
        pat = '{21'sd1048575, 21'sd524288, 21'sd524287, -21'sd524288,
                -21'sd524289, -21'sd1048576, 21'sd0, 21'sd7};
        pb  = '{8'h01, 8'h01, 8'h00, 8'h00, neg(8'hFF), neg(8'hFF), 8'h00, 8'h00};
        for (int v = 0; v < AS; v++)
            for (int l = 0; l < AS; l++) begin
                tile_data[v][l] = pat[l];
                exp_byte[v][l] = pb[l];
            end
        run_tile("t3b", 10'h030, 5'd20, 21'sd0, -1, -1);

        // Distinct bytes per vector/lane expose loss, duplication or reordering.
        for (int v = 0; v < AS; v++)
            for (int l = 0; l < AS; l++) begin
                tile_data[v][l] = 21'(16 * v + l);
                exp_byte[v][l] = 8'(16 * v + l);
            end
        run_tile("t4", 10'h040, 5'd0, 21'sd0, 4, -1);

        // Reset after three vectors accepted, then a clean tile.
        cfg_base_addr = 10'h050;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (matrix_index != 6'd3 && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        check("t5 reached index 3", 64'(matrix_index), 64'd3);
        srstn = 1'b0;
        @(posedge clk);
        #1;
        check("t5 rst out_valid", 64'(out_valid), 64'd0);
        check("t5 rst wdata", out_wdata, 64'd0);
        check("t5 rst addr", 64'(out_addr), 64'd0);
        check("t5 rst busy", 64'(busy), 64'd0);
        check("t5 rst index", 64'(matrix_index), 64'd0);
        check("t5 rst vec_ready", 64'(vec_ready), 64'd0);
        srstn = 1'b1;
        q0 = got_data.size();
        repeat (5) @(posedge clk);
        #1;
        check("t5 no stray write", 64'(got_data.size() - q0), 64'd0);
        run_tile("t5", 10'h060, 5'd0, 21'sd0, -1, -1);

        // start during RUN is ignored; next tile starts the cycle after done.
        run_tile("t6a", 10'h200, 5'd0, 21'sd0, -1, 3);
        for (int v = 0; v < AS; v++)
            for (int l = 0; l < AS; l++) begin
                tile_data[v][l] = 21'(100 - 8 * v - l);
                exp_byte[v][l] = 8'(100 - 8 * v - l);
            end
        run_tile("t6b", 10'h3F8, 5'd0, 21'sd0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
